gat_run_ctrl: RTL and testbench

GAT_RUN_CTRL -- requirements
Module: gat_run_ctrl

---
 rtl/gat_run_ctrl_pkg.sv | 18 +
 rtl/gat_sat_counter.sv | 16 +
 rtl/gat_run_ctrl.sv | 104 ++++++++++
 tb/tb_gat_run_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/gat_run_ctrl_pkg.sv
// gat_run_ctrl_pkg: run-controller states, debug_3 bit positions and default watchdog limit
package gat_run_ctrl_pkg;
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOAD = 3'd1,
        ST_START     = 3'd2,
        ST_RUN       = 3'd3,
        ST_DONE      = 3'd4,
        ST_ERROR     = 3'd5
    } gat_state_e;
    localparam int DBG_STATE_LSB  = 0;
    localparam int DBG_HDATA      = 3;
    localparam int DBG_NODE       = 4;
    localparam int DBG_WGT        = 5;
    localparam int DBG_OVF        = 6;
    localparam int DBG_WDT        = 7;
    localparam int DEF_WDT_CYCLES = 65536;
endpackage

// File: rtl/gat_sat_counter.sv
// gat_sat_counter: up-counter with synchronous clear that sticks at all-ones instead of wrapping
module gat_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= '0;
        else if (clr) q <= '0;
        else if (en && !(&q)) q <= q + 1'b1;
    end
endmodule

// File: rtl/gat_run_ctrl.sv
// gat_run_ctrl: sequences host BRAM loads, datapath launch and subgraph completion for one GAT run.
// Optional RUN watchdog is built in when GAT_RUN_WDT_EN is defined.
module gat_run_ctrl
    import gat_run_ctrl_pkg::*;
#(
    parameter int TOP_WIDTH     = 32,
    parameter int NUM_SUBGRAPHS = 2708,
    parameter int WDT_CYCLES    = DEF_WDT_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 h_data_bram_load_done,
    input  logic                 h_node_info_bram_load_done,
    input  logic                 wgt_bram_load_done,
    input  logic                 soft_clear,
    input  logic                 sg_done,
    output logic                 gat_start,
    output logic                 gat_busy,
    output logic                 gat_ready,
    output logic [TOP_WIDTH-1:0] gat_debug_1,
    output logic [TOP_WIDTH-1:0] gat_debug_2,
    output logic [TOP_WIDTH-1:0] gat_debug_3
);
    localparam int SG_W = $clog2(NUM_SUBGRAPHS + 1);
    gat_state_e      state;
    logic            f_h, f_node, f_wgt, ovf, wdt_trip, wdt_err;
    logic [SG_W-1:0] sg_cnt;
    logic            sg_last;
    assign sg_last = sg_cnt == SG_W'(NUM_SUBGRAPHS - 1);
`ifdef GAT_RUN_WDT_EN
    localparam int WD_W = $clog2(WDT_CYCLES + 1);
    logic [WD_W-1:0] wdt_cnt;
    // Held at zero outside RUN, so entering RUN always starts a fresh idle window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) wdt_cnt <= '0;
        else if (soft_clear || state != ST_RUN || sg_done) wdt_cnt <= '0;
        else wdt_cnt <= wdt_cnt + 1'b1;
    end
    assign wdt_trip = state == ST_RUN && !sg_done && wdt_cnt == WD_W'(WDT_CYCLES - 1);
    assign wdt_err  = state == ST_ERROR;
`else
    assign wdt_trip = 1'b0;
    assign wdt_err  = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                  <= ST_IDLE;
            {f_h, f_node, f_wgt}   <= '0;
            ovf                    <= 1'b0;
            sg_cnt                 <= '0;
            {gat_start, gat_busy, gat_ready} <= '0;
        end else if (soft_clear) begin
            state                  <= ST_IDLE;
            {f_h, f_node, f_wgt}   <= '0;
            ovf                    <= 1'b0;
            sg_cnt                 <= '0;
            {gat_start, gat_busy, gat_ready} <= '0;
        end else begin
            gat_start <= 1'b0;
            if (state == ST_IDLE || state == ST_WAIT_LOAD)
                {f_h, f_node, f_wgt} <= {f_h, f_node, f_wgt} |
                    {h_data_bram_load_done, h_node_info_bram_load_done, wgt_bram_load_done};
            if (sg_done && state != ST_RUN) ovf <= 1'b1;
            case (state)
                ST_IDLE: state <= ST_WAIT_LOAD;
                ST_WAIT_LOAD: if (f_h && f_node && f_wgt) begin
                    state     <= ST_START;
                    gat_start <= 1'b1;
                    gat_busy  <= 1'b1;
                end
                ST_START: state <= ST_RUN;
                ST_RUN: if (wdt_trip) begin
                    state    <= ST_ERROR;
                    gat_busy <= 1'b0;
                end else if (sg_done) begin
                    sg_cnt <= sg_cnt + 1'b1;
                    if (sg_last) begin
                        state     <= ST_DONE;
                        gat_busy  <= 1'b0;
                        gat_ready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
    gat_sat_counter #(.W(TOP_WIDTH)) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .clr (soft_clear),
        .en  (state == ST_START || state == ST_RUN),
        .q   (gat_debug_1)
    );
    assign gat_debug_2 = TOP_WIDTH'(sg_cnt);
    always_comb begin
        gat_debug_3                        = '0;
        gat_debug_3[DBG_STATE_LSB +: 3]    = state;
        gat_debug_3[DBG_HDATA]             = f_h;
        gat_debug_3[DBG_NODE]              = f_node;
        gat_debug_3[DBG_WGT]               = f_wgt;
        gat_debug_3[DBG_OVF]               = ovf;
        gat_debug_3[DBG_WDT]               = wdt_err;
    end
endmodule

// File: tb/tb_gat_run_ctrl.sv
// tb_gat_run_ctrl: directed and random stimulus for gat_run_ctrl checked against a cycle-level reference model.
// Watchdog expectations follow GAT_RUN_WDT_EN.
module tb_gat_run_ctrl;
    localparam int TW   = 8;
    localparam int NSG  = 4;
    localparam int WDT  = 16;
    localparam int MAXC = (1 << TW) - 1;
`ifdef GAT_RUN_WDT_EN
    localparam bit WDT_ON = 1'b1;
`else
    localparam bit WDT_ON = 1'b0;
`endif
    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ld_h = 1'b0, ld_n = 1'b0, ld_w = 1'b0, soft_clear = 1'b0, sg_done = 1'b0;
    logic          gat_start, gat_busy, gat_ready;
    logic [TW-1:0] d1, d2, d3;
    int            checks = 0, errors = 0;
    int            m_st, m_cyc, m_sg, m_idle;
    logic          m_fh, m_fn, m_fw, m_ovf;
    int            step_no, start_cnt, start_step;
    int            last_ld;

    always #5 clk = ~clk;

    gat_run_ctrl #(.TOP_WIDTH(TW), .NUM_SUBGRAPHS(NSG), .WDT_CYCLES(WDT)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .h_data_bram_load_done      (ld_h),
        .h_node_info_bram_load_done (ld_n),
        .wgt_bram_load_done         (ld_w),
        .soft_clear                 (soft_clear),
        .sg_done                    (sg_done),
        .gat_start                  (gat_start),
        .gat_busy                   (gat_busy),
        .gat_ready                  (gat_ready),
        .gat_debug_1                (d1),
        .gat_debug_2                (d2),
        .gat_debug_3                (d3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_cyc = 0; m_sg = 0; m_idle = 0;
        m_fh = 1'b0; m_fn = 1'b0; m_fw = 1'b0; m_ovf = 1'b0;
    endtask

    // States: 0 idle, 1 wait-load, 2 start, 3 run, 4 done, 5 error.
    task automatic model_clock(input logic h, input logic n, input logic w, input logic sg, input logic sc);
        int   s;
        logic all;
        if (sc) begin
            model_reset();
            return;
        end
        s   = m_st;
        all = m_fh && m_fn && m_fw;
        if (s <= 1) begin
            m_fh = m_fh | h;
            m_fn = m_fn | n;
            m_fw = m_fw | w;
        end
        if (s == 2 || s == 3) m_cyc = (m_cyc == MAXC) ? MAXC : m_cyc + 1;
        if (sg && s != 3) m_ovf = 1'b1;
        if (s == 0) m_st = 1;
        else if (s == 1 && all) m_st = 2;
        else if (s == 2) begin
            m_st   = 3;
            m_idle = 0;
        end else if (s == 3) begin
            if (sg) begin
                m_sg++;
                m_idle = 0;
                if (m_sg == NSG) m_st = 4;
            end else begin
                m_idle++;
                if (WDT_ON && m_idle == WDT) m_st = 5;
            end
        end
    endtask

    task automatic check_outputs();
        chk("gat_start", 32'(gat_start), 32'(m_st == 2));
        chk("gat_busy",  32'(gat_busy),  32'(m_st == 2 || m_st == 3));
        chk("gat_ready", 32'(gat_ready), 32'(m_st == 4));
        chk("debug_1",   32'(d1), 32'(m_cyc));
        chk("debug_2",   32'(d2), 32'(m_sg));
        chk("debug_3",   32'(d3), 32'(m_st | (int'(m_fh) << 3) | (int'(m_fn) << 4) | (int'(m_fw) << 5)
                                      | (int'(m_ovf) << 6) | (int'(m_st == 5) << 7)));
    endtask

    task automatic step(input logic h, input logic n, input logic w, input logic sg, input logic sc);
        ld_h = h; ld_n = n; ld_w = w; sg_done = sg; soft_clear = sc;
        @(posedge clk);
        model_clock(h, n, w, sg, sc);
        step_no++;
        @(negedge clk);
        if (gat_start) begin
            start_cnt++;
            start_step = step_no;
        end
        check_outputs();
    endtask

    initial begin
        model_reset();
        #2 rst = 1'b1;
        #1 check_outputs();
        @(negedge clk);
        rst = 1'b0;
        // Staggered loads, then four completions.
        step_no = 0; start_cnt = 0; start_step = 0; last_ld = 9;
        for (int k = 1; k <= 12; k++) step(k >= 2, k >= 5, k >= last_ld, 1'b0, 1'b0);
        chk("start_once", 32'(start_cnt), 32'd1);
        chk("start_step", 32'(start_step), 32'(last_ld + 1));
        for (int p = 0; p < NSG; p++) begin
            repeat ($urandom_range(0, 3)) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        end
        repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("ready_done", 32'(gat_ready), 32'd1);
        chk("d2_done", 32'(d2), 32'(NSG));
        chk("d3_state_done", 32'(d3[2:0]), 32'd4);
        chk("start_once_total", 32'(start_cnt), 32'd1);
        // Simultaneous loads after an early completion pulse.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("start_next", 32'(gat_start), 32'd1);
        chk("ovf_early", 32'(d3[6]), 32'd1);
        chk("d2_before_run", 32'(d2), 32'd0);
        // soft_clear collides with the final completion.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (NSG - 1) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("sc_state", 32'(d3[2:0]), 32'd0);
        chk("sc_d1", 32'(d1), 32'd0);
        chk("sc_d2", 32'(d2), 32'd0);
        chk("sc_d3", 32'(d3), 32'd0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sc_no_ready", 32'(gat_ready), 32'd0);
        // Random traffic.
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 99) < 2);
        // Asynchronous reset mid-run at debug_1 = 37.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 60 && m_cyc < 37; k++)
            step(1'b0, 1'b0, 1'b0, (m_cyc % 10 == 9) && (m_sg < NSG - 1), 1'b0);
        chk("pre_rst_d1", 32'(d1), 32'd37);
        #2 rst = 1'b1;
        #1 model_reset();
        check_outputs();
        chk("rst_busy", 32'(gat_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_wait_load", 32'(d3[2:0]), 32'd1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("restart", 32'(gat_start), 32'd1);
        // Long stall in RUN: watchdog trip or counter saturation.
        repeat (300) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef GAT_RUN_WDT_EN
        chk("wdt_state", 32'(d3[2:0]), 32'd5);
        chk("wdt_bit", 32'(d3[7]), 32'd1);
        chk("wdt_busy", 32'(gat_busy), 32'd0);
`else
        chk("sat_d1", 32'(d1), 32'(MAXC));
        chk("stall_state", 32'(d3[2:0]), 32'd3);
        chk("stall_busy", 32'(gat_busy), 32'd1);
`endif
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("final_clear", 32'(d3), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
